ex_div_ctrl: RTL and testbench

EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

---
 rtl/ex_div_ctrl.sv | 126 ++++++++++++
 tb/tb_ex_div_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - EX-stage divide controller: issues divides, holds operands, writes HI/LO, drains after flush
module ex_div_ctrl #(
   parameter logic [7:0] DIV_OP  = 8'b00011010,
   parameter logic [7:0] DIVU_OP = 8'b00011011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   output logic        div_start_o,
   output logic        signed_div_o,
   output logic        div_annul_o,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  cnt;
   logic [1:0]  cnt_nxt;
   logic [31:0] op1_q;
   logic [31:0] op2_q;
   logic        sign_q;
   logic        latch_en;
   logic        is_div;

   assign is_div = (aluop_i == DIV_OP) || (aluop_i == DIVU_OP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 2'd0;
         op1_q  <= 32'd0;
         op2_q  <= 32'd0;
         sign_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch_en) begin
            op1_q  <= reg1_i;
            op2_q  <= reg2_i;
            sign_q <= (aluop_i == DIV_OP);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      latch_en      = 1'b0;
      div_opdata1_o = 32'd0;
      div_opdata2_o = 32'd0;
      div_start_o   = 1'b0;
      signed_div_o  = 1'b0;
      div_annul_o   = 1'b0;
      stallreq_o    = 1'b0;
      whilo_o       = 1'b0;
      hi_o          = 32'd0;
      lo_o          = 32'd0;
      case (state)
         IDLE: begin
            if (is_div && !flush_i) begin
               div_start_o   = 1'b1;
               stallreq_o    = 1'b1;
               div_opdata1_o = reg1_i;
               div_opdata2_o = reg2_i;
               signed_div_o  = (aluop_i == DIV_OP);
               latch_en      = 1'b1;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            // The pipeline may change its operand path while stalled, so only the latched copies are used here
            div_opdata1_o = op1_q;
            div_opdata2_o = op2_q;
            signed_div_o  = sign_q;
            if (flush_i) begin
               div_annul_o = 1'b1;
               cnt_nxt     = 2'd3;
               state_nxt   = DRAIN;
            end else if (div_ready_i) begin
               whilo_o   = 1'b1;
               hi_o      = div_result_i[63:32];
               lo_o      = div_result_i[31:0];
               state_nxt = IDLE;
            end else begin
               div_start_o = 1'b1;
               stallreq_o  = 1'b1;
            end
         end
         DRAIN: begin
            // A divide arriving now is held off until the cancelled one has fully left the divider
            stallreq_o = is_div;
            if (cnt != 2'd0) begin
               cnt_nxt = cnt - 2'd1;
            end else if (!div_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         latch_en      = 1'b0;
         div_opdata1_o = 32'd0;
         div_opdata2_o = 32'd0;
         div_start_o   = 1'b0;
         signed_div_o  = 1'b0;
         div_annul_o   = 1'b0;
         stallreq_o    = 1'b0;
         whilo_o       = 1'b0;
         hi_o          = 32'd0;
         lo_o          = 32'd0;
      end
   end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - randomized self-checking bench for ex_div_ctrl
module tb_ex_div_ctrl;

   localparam logic [7:0] DIV_OP  = 8'b00011010;
   localparam logic [7:0] DIVU_OP = 8'b00011011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  aluop = 8'd0;
   logic [31:0] reg1 = 32'd0;
   logic [31:0] reg2 = 32'd0;
   logic        flush = 1'b0;
   logic [63:0] div_result = 64'd0;
   logic        div_ready = 1'b0;
   logic [31:0] div_opdata1;
   logic [31:0] div_opdata2;
   logic        div_start;
   logic        signed_div;
   logic        div_annul;
   logic        stallreq;
   logic        whilo;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   ex_div_ctrl #(.DIV_OP(DIV_OP), .DIVU_OP(DIVU_OP)) dut (
      .clk          (clk),
      .rst          (rst),
      .aluop_i      (aluop),
      .reg1_i       (reg1),
      .reg2_i       (reg2),
      .flush_i      (flush),
      .div_result_i (div_result),
      .div_ready_i  (div_ready),
      .div_opdata1_o(div_opdata1),
      .div_opdata2_o(div_opdata2),
      .div_start_o  (div_start),
      .signed_div_o (signed_div),
      .div_annul_o  (div_annul),
      .stallreq_o   (stallreq),
      .whilo_o      (whilo),
      .hi_o         (hi),
      .lo_o         (lo)
   );

   always #5 clk = ~clk;

   // Packed as {start, stall, signed, annul, whilo, opdata1, opdata2, hi, lo}
   function automatic logic [132:0] pack(input logic st, input logic sl, input logic sg,
                                         input logic an, input logic wh,
                                         input logic [31:0] o1, input logic [31:0] o2,
                                         input logic [31:0] h, input logic [31:0] l);
      return {st, sl, sg, an, wh, o1, o2, h, l};
   endfunction

   function automatic logic [132:0] obs();
      return pack(div_start, stallreq, signed_div, div_annul, whilo,
                  div_opdata1, div_opdata2, hi, lo);
   endfunction

   task automatic check(input string tag, input logic [132:0] got, input logic [132:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // Divider behaviour: {remainder, quotient}, zero for a zero divisor
   function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (op == DIV_OP) begin
         sa = $signed(a);
         sb = $signed(b);
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at);
      logic        sgn;
      logic [63:0] res;
      sgn = (op == DIV_OP);
      res = model(op, a, b);
      @(negedge clk);
      aluop = op; reg1 = a; reg2 = b; flush = 1'b0; div_ready = 1'b0;
      div_result = {$urandom, $urandom};
      #1 check("issue", obs(), pack(1, 1, sgn, 0, 0, a, b, 0, 0));
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         aluop = 8'($urandom); reg1 = $urandom; reg2 = $urandom;
         div_result = {$urandom, $urandom};
         if (k == flush_at) begin
            flush = 1'b1;
            div_ready = 1'($urandom);
            #1 check("flush", obs(), pack(0, 0, sgn, 1, 0, a, b, 0, 0));
            return;
         end
         flush = 1'b0;
         if (k == lat) begin
            div_ready = 1'b1;
            div_result = res;
            #1 check("done", obs(), pack(0, 0, sgn, 0, 1, a, b, res[63:32], res[31:0]));
         end else begin
            div_ready = 1'b0;
            #1 check("wait", obs(), pack(1, 1, sgn, 0, 0, a, b, 0, 0));
         end
      end
   endtask

   // Counter loaded with 3 and counted to 0 gives four drain cycles before IDLE, one more if ready lingers
   task automatic drain(input logic present, input logic hold);
      int n;
      n = hold ? 5 : 4;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         aluop = present ? DIVU_OP : 8'h00;
         reg1 = $urandom; reg2 = $urandom;
         flush = 1'($urandom);
         div_result = {$urandom, $urandom};
         if (i < 3) div_ready = 1'($urandom);
         else div_ready = (hold && i == 3);
         #1 check("drain", obs(), pack(0, present, 0, 0, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic idle();
      int pick;
      pick = $urandom_range(0, 2);
      @(negedge clk);
      reg1 = $urandom; reg2 = $urandom; div_ready = 1'b0;
      div_result = {$urandom, $urandom};
      if (pick == 0) begin
         aluop = 8'h00; flush = 1'($urandom);
      end else if (pick == 1) begin
         aluop = $urandom_range(0, 1) ? DIV_OP : DIVU_OP; flush = 1'b1;
      end else begin
         aluop = 8'($urandom) & 8'hF0; flush = 1'b0;
      end
      #1 check("idle", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int          lat, fl;

      aluop = DIVU_OP; reg1 = 32'd5; reg2 = 32'd1;
      #1 check("reset", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0; aluop = 8'h00;

      run_div(DIVU_OP, 32'd100, 32'd7, 5, -1);
      idle();
      run_div(DIV_OP, 32'hFFFFFFF9, 32'd2, 3, -1);
      idle();
      run_div(DIVU_OP, 32'd123, 32'd4, 15, 10);
      drain(1'b0, 1'b0);
      run_div(DIVU_OP, 32'd9, 32'd3, 4, -1);
      idle();
      run_div(DIVU_OP, 32'd5, 32'd0, 2, -1);
      run_div(DIV_OP, 32'h80000000, 32'hFFFFFFFF, 1, -1);
      idle();
      run_div(DIV_OP, 32'd77, 32'hFFFFFFF6, 6, 6);
      drain(1'b1, 1'b1);
      run_div(DIVU_OP, 32'd1000, 32'd33, 2, -1);
      idle();

      // Asynchronous reset mid-divide, then confirm the divide is forgotten
      @(negedge clk);
      aluop = DIVU_OP; reg1 = 32'd50; reg2 = 32'd5; flush = 1'b0; div_ready = 1'b0;
      #1 check("rst_issue", obs(), pack(1, 1, 0, 0, 0, 32'd50, 32'd5, 0, 0));
      @(negedge clk);
      aluop = 8'h00;
      #1 check("rst_wait", obs(), pack(1, 1, 0, 0, 0, 32'd50, 32'd5, 0, 0));
      #2 rst = 1'b1;
      #1 check("rst_async", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0; div_ready = 1'b1; div_result = 64'h0000_0003_0000_000A;
      #1 check("rst_idle", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      div_ready = 1'b0;
      #1 check("rst_after", obs(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 1) ? DIV_OP : DIVU_OP;
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 20);
            2:       b = -32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         lat = $urandom_range(1, 12);
         fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : -1;
         run_div(op, a, b, lat, fl);
         if (fl > 0) drain(1'($urandom), $urandom_range(0, 3) == 0);
         else if ($urandom_range(0, 2) != 0) idle();
      end
      idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
